// File: rtl/writeback_queue_if.sv
// rtl/writeback_queue_if.sv - result inputs and register file write port of the writeback queue
interface writeback_queue_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 4
) ();
  logic              alu_valid;
  logic [REG_W-1:0]  alu_dReg;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;
  logic              mem_valid;
  logic [REG_W-1:0]  mem_dReg;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ready;
  logic              writeEnable;
  logic [REG_W-1:0]  dReg;
  logic [DATA_W-1:0] wrData;

  modport master (
    output alu_valid, alu_dReg, alu_data, input alu_ready,
    output mem_valid, mem_dReg, mem_data, input mem_ready,
    input  writeEnable, dReg, wrData
  );

  modport slave (
    input  alu_valid, alu_dReg, alu_data, output alu_ready,
    input  mem_valid, mem_dReg, mem_data, output mem_ready,
    output writeEnable, dReg, wrData
  );
endinterface

// File: rtl/writeback_queue.sv
// rtl/writeback_queue.sv - in-order result queue feeding the register file write port
module writeback_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int REG_W  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  writeback_queue_if.slave         bus,
  input  logic [REG_W-1:0]         operand1,
  input  logic [REG_W-1:0]         operand2,
  output logic                     hazard1,
  output logic                     hazard2,
  output logic                     wb_dropped,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [REG_W-1:0]  q_reg  [DEPTH];
  logic [DATA_W-1:0] q_data [DEPTH];
  logic [PTR_W-1:0]  head, tail, alu_slot;
  logic [CNT_W-1:0]  cnt, n_acc;
  logic              mem_acc, alu_acc, pop, head_prot;
  logic              we_q, drop_q;
  logic [REG_W-1:0]  dreg_q;
  logic [DATA_W-1:0] wdata_q;

  // Readiness looks only at registered occupancy; a same-cycle pop never frees a slot early.
  assign bus.mem_ready = cnt < CNT_W'(DEPTH);
  assign bus.alu_ready = cnt <= CNT_W'(DEPTH - 2);
  assign mem_acc       = bus.mem_valid & bus.mem_ready;
  assign alu_acc       = bus.alu_valid & bus.alu_ready;
  assign pop           = cnt != '0;
  assign head_prot     = (q_reg[head] == REG_W'(14)) || (q_reg[head] == REG_W'(15));
  assign alu_slot      = tail + PTR_W'(mem_acc);
  assign n_acc         = CNT_W'(mem_acc) + CNT_W'(alu_acc);

  assign bus.writeEnable = we_q;
  assign bus.dReg        = dreg_q;
  assign bus.wrData      = wdata_q;
  assign wb_dropped      = drop_q;
  assign count           = cnt;

  // Mem goes in first so it is older than a same-cycle ALU result.
  always_ff @(posedge clk) begin
    if (mem_acc) begin
      q_reg[tail]  <= bus.mem_dReg;
      q_data[tail] <= bus.mem_data;
    end
    if (alu_acc) begin
      q_reg[alu_slot]  <= bus.alu_dReg;
      q_data[alu_slot] <= bus.alu_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head    <= '0;
      tail    <= '0;
      cnt     <= '0;
      we_q    <= 1'b0;
      drop_q  <= 1'b0;
      dreg_q  <= '0;
      wdata_q <= '0;
    end else begin
      tail <= tail + PTR_W'(n_acc);
      head <= head + PTR_W'(pop);
      cnt  <= cnt + n_acc - CNT_W'(pop);
      if (pop) begin
        dreg_q  <= q_reg[head];
        wdata_q <= q_data[head];
        we_q    <= !head_prot;
        drop_q  <= head_prot;
      end else begin
        we_q   <= 1'b0;
        drop_q <= 1'b0;
      end
    end
  end

  always_comb begin
    logic [PTR_W-1:0] off;
    logic             live, prot;
    off     = '0;
    live    = 1'b0;
    prot    = 1'b0;
    hazard1 = we_q && (dreg_q == operand1);
    hazard2 = we_q && (dreg_q == operand2);
    for (int s = 0; s < DEPTH; s++) begin
      off  = PTR_W'(s) - head;
      live = {1'b0, off} < cnt;
      prot = (q_reg[s] == REG_W'(14)) || (q_reg[s] == REG_W'(15));
      if (live && !prot && (q_reg[s] == operand1)) hazard1 = 1'b1;
      if (live && !prot && (q_reg[s] == operand2)) hazard2 = 1'b1;
    end
  end
endmodule

// File: tb/tb_writeback_queue.sv
// tb/tb_writeback_queue.sv - scoreboard bench for writeback_queue
module tb_writeback_queue;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] operand1 = 4'd0;
  logic [3:0] operand2 = 4'd0;
  logic       hazard1, hazard2, wb_dropped;
  logic [2:0] count;

  always #5 clk = ~clk;

  writeback_queue_if #(.DATA_W(32), .REG_W(4)) bus ();

  writeback_queue #(.DEPTH(4), .DATA_W(32), .REG_W(4)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .operand1(operand1), .operand2(operand2),
    .hazard1(hazard1), .hazard2(hazard2),
    .wb_dropped(wb_dropped), .count(count)
  );

  typedef struct packed {
    logic [3:0]  r;
    logic [31:0] d;
  } ent_t;

  ent_t        sb[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic        exp_we = 1'b0;
  logic        exp_drop = 1'b0;
  logic [3:0]  exp_dreg = 4'd0;
  logic [31:0] exp_wdata = 32'd0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic exp_haz(input logic [3:0] op);
    logic h;
    h = exp_we && (exp_dreg == op);
    foreach (sb[i]) if (sb[i].r == op && sb[i].r < 4'd14) h = 1'b1;
    return h;
  endfunction

  // One cycle: drive at negedge, enqueue into the model, pop at posedge, check at next negedge.
  task automatic step(input logic av, input logic [3:0] ar, input logic [31:0] ad,
                      input logic mv, input logic [3:0] mr, input logic [31:0] md);
    int   n0;
    logic er_mem, er_alu;
    ent_t popped;
    bus.alu_valid = av; bus.alu_dReg = ar; bus.alu_data = ad;
    bus.mem_valid = mv; bus.mem_dReg = mr; bus.mem_data = md;
    #1;
    n0     = sb.size();
    er_mem = n0 < 4;
    er_alu = n0 <= 2;
    check("mem_ready", bus.mem_ready, er_mem);
    check("alu_ready", bus.alu_ready, er_alu);
    if (mv && er_mem) sb.push_back(ent_t'{r: mr, d: md});
    if (av && er_alu) sb.push_back(ent_t'{r: ar, d: ad});
    @(posedge clk);
    if (n0 > 0) begin
      popped    = sb.pop_front();
      exp_dreg  = popped.r;
      exp_wdata = popped.d;
      exp_we    = popped.r < 4'd14;
      exp_drop  = !exp_we;
    end else begin
      exp_we   = 1'b0;
      exp_drop = 1'b0;
    end
    @(negedge clk);
    check("writeEnable", bus.writeEnable, exp_we);
    check("dReg", bus.dReg, exp_dreg);
    check("wrData", bus.wrData, exp_wdata);
    check("wb_dropped", wb_dropped, exp_drop);
    check("count", count, sb.size());
    check("hazard1", hazard1, exp_haz(operand1));
    check("hazard2", hazard2, exp_haz(operand2));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
  endtask

  initial begin
    bus.alu_valid = 1'b0; bus.alu_dReg = 4'd0; bus.alu_data = 32'd0;
    bus.mem_valid = 1'b0; bus.mem_dReg = 4'd0; bus.mem_data = 32'd0;
    #12;
    check("rst_count", count, 0);
    check("rst_we", bus.writeEnable, 0);
    check("rst_dreg", bus.dReg, 0);
    check("rst_wrdata", bus.wrData, 0);
    check("rst_drop", wb_dropped, 0);
    check("rst_alu_ready", bus.alu_ready, 1);
    check("rst_mem_ready", bus.mem_ready, 1);
    check("rst_haz1", hazard1, 0);
    check("rst_haz2", hazard2, 0);
    @(negedge clk);
    reset = 1'b0;

    // single ALU write
    step(1'b1, 4'd3, 32'hA5, 1'b0, 4'd0, 32'd0);
    idle(3);

    // simultaneous mem + alu into an empty queue
    step(1'b1, 4'd6, 32'h22, 1'b1, 4'd5, 32'h11);
    idle(3);

    // backpressure with both inputs held valid
    for (int i = 0; i < 8; i++)
      step(1'b1, 4'(i % 14), 32'h100 + 32'(i), 1'b1, 4'((i + 7) % 14), 32'h200 + 32'(i));
    idle(4);

    // protected destination
    operand1 = 4'd14;
    step(1'b0, 4'd0, 32'd0, 1'b1, 4'd14, 32'hFF);
    idle(2);

    // hazard tracking through the output stage
    operand2 = 4'd7;
    step(1'b1, 4'd7, 32'h77, 1'b0, 4'd0, 32'd0);
    idle(3);

    // random traffic, including r14/r15 and wraparound
    for (int i = 0; i < 40; i++) begin
      operand1 = 4'($urandom_range(15));
      operand2 = 4'($urandom_range(15));
      step(1'($urandom_range(1)), 4'($urandom_range(15)), $urandom,
           1'($urandom_range(1)), 4'($urandom_range(15)), $urandom);
    end
    idle(4);

    // asynchronous reset with three entries pending
    operand1 = 4'd1;
    operand2 = 4'd2;
    step(1'b1, 4'd1, 32'hAAAA, 1'b1, 4'd2, 32'hBBBB);
    step(1'b1, 4'd3, 32'hCCCC, 1'b1, 4'd4, 32'hDDDD);
    check("pre_reset_count", count, 3);
    bus.alu_valid = 1'b0;
    bus.mem_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("async_count", count, 0);
    check("async_we", bus.writeEnable, 0);
    check("async_haz1", hazard1, 0);
    sb.delete();
    exp_we = 1'b0; exp_drop = 1'b0; exp_dreg = 4'd0; exp_wdata = 32'd0;
    @(negedge clk);
    reset = 1'b0;
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
